pll_lock_supervisor: RTL and testbench
======================================

# pll_lock_supervisor

Reset-side controller for the HPS/fabric PLL. It runs on the PLL reference clock and drives the PLL reset. It watches the PLL lock flag, waits for lock to stay stable, and then releases a system reset for logic clocked from the PLL outputs. It also retries on lock timeout, re-sequences on lock loss or software request, and latches a fault after repeated failures.

## Interface
- RST_PULSE_CYCLES, 16: refclk cycles `pll_rst` is held high per reset attempt (≥1).
- LOCK_TIMEOUT_CYCLES, 50000: cycles allowed in WAIT_LOCK before a retry (1 ms at 50 MHz).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before release (≥1).
- MAX_RETRIES, 3: number of timeouts that forces FAULT (≥1).

Ports:
- refclk  in  1  single clock, 50 MHz PLL reference.
- rst_n  in  1  asynchronous, active-low reset.
- pll_locked  in  1  raw `locked` from the PLL; asynchronous to refclk.
- relock_req  in  1  one-cycle software request to re-lock; level-sampled.
- pll_rst  out  1  active-high PLL reset.
- sys_rst_n  out  1  active-low reset for PLL-clocked logic; synchronous to refclk.
- ready  out  1  high only in RUN.
- fault  out  1  high only in FAULT.
- loss_count  out  8  saturating count of lock losses seen in RUN.
- retry_count  out  2  timeouts since last successful lock.

## Operation
- `pll_locked` passes through a 2-flop synchronizer; `lock_s` is its output. The FSM uses only `lock_s`.
- A single down-counter `timer` is reloaded on every state entry.
- **RESET_PLL**
  - `pll_rst`=1.
  - After RST_PULSE_CYCLES cycles in this state, go to WAIT_LOCK.
- **WAIT_LOCK**
  - `pll_rst`=0.
  - If `lock_s`=1, go to STABILIZE.
  - Otherwise, after LOCK_TIMEOUT_CYCLES cycles, increment `retry_count`.
  - If the new `retry_count` equals MAX_RETRIES, go to FAULT; otherwise go to RESET_PLL.
- **STABILIZE**
  - Any `lock_s`=0 cycle returns to WAIT_LOCK; the timeout is restarted and `retry_count` is unchanged.
  - After LOCK_STABLE_CYCLES consecutive `lock_s`=1 cycles, go to RUN and clear `retry_count` to 0.
- **RUN**
  - `sys_rst_n`=1, `ready`=1.
  - If `lock_s`=0, increment `loss_count` (saturating at 255) and go to RESET_PLL.
  - Else if `relock_req`=1, go to RESET_PLL without counting.
  - If both occur in the same cycle, the loss is counted.
- **FAULT**
  - `pll_rst`=1 is held, `fault`=1.
  - Exit only on `relock_req`=1, which clears `retry_count` and goes to RESET_PLL; `loss_count` is kept.
- `relock_req` is ignored in RESET_PLL, WAIT_LOCK and STABILIZE.
- `sys_rst_n`, `ready` and `fault` are registered decodes of the next state. They change on the same edge as the state transition.
- `sys_rst_n`=0 in every state except RUN.
- Arithmetic:
  - `timer` width is clog2 of the largest cycle parameter.
  - `loss_count` saturates and never wraps.
  - `retry_count` never exceeds MAX_RETRIES.

## Timing
- Reset values while `rst_n`=0:
  - state RESET_PLL
  - `pll_rst`=1, `sys_rst_n`=0, `ready`=0, `fault`=0
  - `loss_count`=0, `retry_count`=0, synchronizer flops 0
- Reset assertion is immediate and asynchronous. Deassertion is sampled at the first refclk rising edge with `rst_n`=1, which is edge 0.
- `pll_rst` falls after edge RST_PULSE_CYCLES.
- Lock latency: let E be the first edge that samples `pll_locked`=1.
  - `lock_s`=1 after E+1.
  - STABILIZE is entered after E+2.
  - `sys_rst_n`/`ready` rise after E+2+LOCK_STABLE_CYCLES.
- Loss latency: let L be the first edge that samples `pll_locked`=0 while in RUN.
  - `sys_rst_n`/`ready` fall after L+2.
  - `pll_rst` rises on the same edge.
- Reset mid-operation (any state): all outputs return to their reset values asynchronously; `loss_count` is cleared.

## Test plan
Parameters for all scenarios: RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=3.

- **Nominal lock:** release `rst_n`; raise `pll_locked` at edge 10 → `pll_rst` high for edges 0–3, low after edge 4; `sys_rst_n`=`ready`=1 after edge 20; `retry_count`=0.
- **Glitch in STABILIZE:** lock, drop `pll_locked` for 1 cycle at STABILIZE cycle 5, then restore → returns to WAIT_LOCK; release occurs 8 full stable cycles after the restore; no `pll_rst` pulse.
- **Timeouts to FAULT:** hold `pll_locked`=0 → three cycles of 4 reset + 20 wait; `fault`=1, `pll_rst`=1, `retry_count`=3. Then pulse `relock_req` and raise lock → `fault`=0, new reset pulse, RUN reached, `retry_count`=0.
- **Loss in RUN:** in RUN, drop `pll_locked` → `sys_rst_n`=0 and `pll_rst`=1 two edges later; `loss_count`=1; relock reaches RUN again.
- **Simultaneous loss + relock_req; saturation:** in RUN, drop lock in the same cycle as `relock_req` → `loss_count` increments. Repeat 260 losses → `loss_count` holds 255.
- **Async reset in RUN:** assert `rst_n`=0 mid-cycle → `sys_rst_n`=0, `pll_rst`=1, `loss_count`=0 immediately without waiting for a clock edge.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : pll_lock_supervisor
// Purpose  : Sequences the PLL reset, waits for a stable lock, then releases
//            the reset of PLL-clocked logic. Retries on lock timeout, latches
//            a fault after repeated timeouts, re-sequences on lock loss or a
//            software relock request.
// Revision : 1.0 - initial release
// ============================================================================
module pll_lock_supervisor #(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [7:0] loss_count,
    output logic [1:0] retry_count
);

    // Timer must hold the largest reload value and the post-reset preload.
    localparam int unsigned c_max_ab     = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                           RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned c_max_cycles = (c_max_ab > LOCK_STABLE_CYCLES) ?
                                           c_max_ab : LOCK_STABLE_CYCLES;
    localparam int unsigned c_timer_w    = $clog2(c_max_cycles + 1);
    localparam logic [1:0]  c_max_retries = 2'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_timer_w-1:0]   r_timer;
    logic [c_timer_w-1:0]   w_timer_nxt;
    logic                   r_sync1;
    logic                   r_lock_s;
    logic [7:0]             r_loss_count;
    logic [7:0]             w_loss_nxt;
    logic [1:0]             r_retry_count;
    logic [1:0]             w_retry_nxt;
    logic [1:0]             w_retry_inc;
    logic                   r_pll_rst;
    logic                   r_sys_rst_n;
    logic                   r_ready;
    logic                   r_fault;

    // Two-flop synchronizer bringing the raw PLL lock flag into refclk.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_lock_s <= 1'b0;
        end else begin
            r_sync1  <= pll_locked;
            r_lock_s <= r_sync1;
        end
    end

    assign w_retry_inc = r_retry_count + 2'd1;

    // Next-state, timer reload and counter updates.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = (r_timer != '0) ? (r_timer - c_timer_w'(1)) : '0;
        w_retry_nxt = r_retry_count;
        w_loss_nxt  = r_loss_count;

        case (r_state)
            ST_RESET_PLL: begin
                if (r_timer == '0) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (r_lock_s) begin
                    w_state_nxt = ST_STABILIZE;
                end else if (r_timer == '0) begin
                    w_retry_nxt = w_retry_inc;
                    w_state_nxt = (w_retry_inc == c_max_retries) ? ST_FAULT : ST_RESET_PLL;
                end
            end
            ST_STABILIZE: begin
                if (!r_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else if (r_timer == '0) begin
                    w_state_nxt = ST_RUN;
                    w_retry_nxt = 2'd0;
                end
            end
            ST_RUN: begin
                // A loss takes precedence and is counted even with a relock request.
                if (!r_lock_s) begin
                    if (r_loss_count != 8'hFF) begin
                        w_loss_nxt = r_loss_count + 8'd1;
                    end
                    w_state_nxt = ST_RESET_PLL;
                end else if (relock_req) begin
                    w_state_nxt = ST_RESET_PLL;
                end
            end
            ST_FAULT: begin
                if (relock_req) begin
                    w_retry_nxt = 2'd0;
                    w_state_nxt = ST_RESET_PLL;
                end
            end
            default: begin
                w_state_nxt = ST_RESET_PLL;
            end
        endcase

        // Every state entry reloads the timer with that state's cycle budget.
        if (w_state_nxt != r_state) begin
            case (w_state_nxt)
                ST_RESET_PLL: w_timer_nxt = c_timer_w'(RST_PULSE_CYCLES - 1);
                ST_WAIT_LOCK: w_timer_nxt = c_timer_w'(LOCK_TIMEOUT_CYCLES - 1);
                ST_STABILIZE: w_timer_nxt = c_timer_w'(LOCK_STABLE_CYCLES - 1);
                default:      w_timer_nxt = '0;
            endcase
        end
    end

    // State, timer, counters and registered output decodes of the next state.
    // The post-reset preload is one longer because the deassertion edge itself
    // is spent in RESET_PLL.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RESET_PLL;
            r_timer       <= c_timer_w'(RST_PULSE_CYCLES);
            r_loss_count  <= 8'd0;
            r_retry_count <= 2'd0;
            r_pll_rst     <= 1'b1;
            r_sys_rst_n   <= 1'b0;
            r_ready       <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            r_loss_count  <= w_loss_nxt;
            r_retry_count <= w_retry_nxt;
            r_pll_rst     <= (w_state_nxt == ST_RESET_PLL) || (w_state_nxt == ST_FAULT);
            r_sys_rst_n   <= (w_state_nxt == ST_RUN);
            r_ready       <= (w_state_nxt == ST_RUN);
            r_fault       <= (w_state_nxt == ST_FAULT);
        end
    end

    assign pll_rst     = r_pll_rst;
    assign sys_rst_n   = r_sys_rst_n;
    assign ready       = r_ready;
    assign fault       = r_fault;
    assign loss_count  = r_loss_count;
    assign retry_count = r_retry_count;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_lock_supervisor
// Purpose  : Directed self-checking bench for pll_lock_supervisor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_lock_supervisor;

    logic       refclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fault;
    logic [7:0] loss_count;
    logic [1:0] retry_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;   // index of the last refclk edge completed after release

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES (20),
        .LOCK_STABLE_CYCLES  (8),
        .MAX_RETRIES         (3)
    ) u_dut (
        .refclk      (refclk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .relock_req  (relock_req),
        .pll_rst     (pll_rst),
        .sys_rst_n   (sys_rst_n),
        .ready       (ready),
        .fault       (fault),
        .loss_count  (loss_count),
        .retry_count (retry_count)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge refclk);
        #1;
        cyc++;
    endtask

    task automatic at(input int n);
        while (cyc < n) step();
    endtask

    // Assert reset mid-cycle, then release just after a rising edge;
    // the next rising edge is edge 0.
    task automatic do_reset();
        @(negedge refclk);
        rst_n = 1'b0;
        @(posedge refclk);
        #1;
        rst_n = 1'b1;
        cyc = -1;
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n;
        n = 0;
        while (!ready && n < budget) begin
            step();
            n++;
        end
        check(tag, ready, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_rst;
        int   exp_loss;

        // Reset values
        repeat (2) @(posedge refclk);
        #1;
        check("rst_pll_rst",   pll_rst, 1);
        check("rst_sys_rst_n", sys_rst_n, 0);
        check("rst_ready",     ready, 0);
        check("rst_fault",     fault, 0);
        check("rst_loss",      loss_count, 0);
        check("rst_retry",     retry_count, 0);
        rst_n = 1'b1;
        cyc = -1;

        // Nominal lock: lock first sampled at edge 10
        at(3);  check("nom_pll_rst_e3", pll_rst, 1);
        at(4);  check("nom_pll_rst_e4", pll_rst, 0);
        at(9);  pll_locked = 1'b1;
        at(19); check("nom_ready_e19", ready, 0);
        at(20); check("nom_ready_e20", ready, 1);
        check("nom_sys_rst_n_e20", sys_rst_n, 1);
        check("nom_retry", retry_count, 0);

        // Loss in RUN: first low sample at edge 25
        at(24); pll_locked = 1'b0;
        at(26); check("loss_sys_rst_n_l1", sys_rst_n, 1);
        at(27); check("loss_sys_rst_n_l2", sys_rst_n, 0);
        check("loss_pll_rst_l2", pll_rst, 1);
        check("loss_count_1", loss_count, 1);
        pll_locked = 1'b1;
        at(39); check("loss_relock_e39", ready, 0);
        at(40); check("loss_relock_e40", ready, 1);

        // Loss and relock_req seen on the same edge (47)
        at(44); pll_locked = 1'b0;
        at(46); relock_req = 1'b1;
        at(47); relock_req = 1'b0;
        check("sim_pll_rst", pll_rst, 1);
        check("sim_loss_count", loss_count, 2);
        pll_locked = 1'b1;
        at(60); check("sim_ready_e60", ready, 1);

        // relock_req alone in RUN: re-sequence without counting
        at(64); relock_req = 1'b1;
        at(65); relock_req = 1'b0;
        check("req_pll_rst", pll_rst, 1);
        check("req_ready", ready, 0);
        check("req_loss_count", loss_count, 2);
        at(78); check("req_ready_e78", ready, 1);

        // Asynchronous reset mid-cycle while in RUN
        at(80);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_sys_rst_n", sys_rst_n, 0);
        check("async_pll_rst",   pll_rst, 1);
        check("async_ready",     ready, 0);
        check("async_loss",      loss_count, 0);
        @(posedge refclk);
        #1;
        rst_n = 1'b1;
        cyc = -1;

        // Glitch in STABILIZE (entered after edge 5), lock held high otherwise
        at(7);  pll_locked = 1'b0;
        at(8);  pll_locked = 1'b1;
        saw_rst = 1'b0;
        while (cyc < 18) begin
            step();
            if (pll_rst) saw_rst = 1'b1;
        end
        check("glitch_no_pll_rst", saw_rst, 0);
        check("glitch_ready_e18", ready, 0);
        at(19); check("glitch_ready_e19", ready, 1);

        // Timeouts to FAULT with lock held low
        pll_locked = 1'b0;
        do_reset();
        at(13); check("to_ready_e13", ready, 0);
        at(23); check("to_pll_rst_e23", pll_rst, 0);
        check("to_retry_e23", retry_count, 0);
        at(24); check("to_pll_rst_e24", pll_rst, 1);
        check("to_retry_e24", retry_count, 1);
        at(48); check("to_retry_e48", retry_count, 2);
        at(71); check("to_fault_e71", fault, 0);
        at(72); check("to_fault_e72", fault, 1);
        check("to_pll_rst_e72", pll_rst, 1);
        check("to_retry_e72", retry_count, 3);
        at(80); check("to_fault_held", fault, 1);
        check("to_pll_rst_held", pll_rst, 1);
        relock_req = 1'b1;
        pll_locked = 1'b1;
        at(81); relock_req = 1'b0;
        check("fault_exit_fault", fault, 0);
        check("fault_exit_retry", retry_count, 0);
        check("fault_exit_pll_rst", pll_rst, 1);
        at(85); check("fault_exit_pll_rst_e85", pll_rst, 0);
        at(93); check("fault_exit_ready_e93", ready, 0);
        at(94); check("fault_exit_ready_e94", ready, 1);
        check("fault_exit_retry_run", retry_count, 0);

        // Saturation of loss_count over 260 losses
        exp_loss = 0;
        for (int i = 0; i < 260; i++) begin
            pll_locked = 1'b0;
            repeat (3) step();
            pll_locked = 1'b1;
            exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
            if (i == 99 || i == 254 || i == 255 || i == 259) begin
                check("sat_loss_count", loss_count, exp_loss);
            end
            wait_ready("sat_relock", 30);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
